// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the register-file dump reader: default sizes and the
// FSM state encoding, also used by the host-readback top.
package regfile_dump_reader_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 16;
    localparam int unsigned DEFAULT_REGBITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SEND   = 3'd2,
        ST_FINISH = 3'd3,
        ST_CSUM   = 3'd4
    } state_e;

endpackage

// File: rtl/regdump_out_reg.sv
// Output word register for the dump stream: loads a word, holds it stable
// until the consumer accepts it.
module regdump_out_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             accept_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // A load in the same cycle as an accept replaces the accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (accept_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range on one regfile read port and streams the
// values over valid/ready. Optional trailing checksum word: REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned REGBITS = DEFAULT_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [REGBITS-1:0] first_addr,
    input  logic [REGBITS-1:0] last_addr,
    output logic [REGBITS-1:0] ra,
    input  logic [WIDTH-1:0]   rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [REGBITS-1:0] cur_q, cur_d;
    logic [REGBITS-1:0] last_q, last_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [WIDTH-1:0]   sum_q, sum_d;
`endif

    logic               load_c;
    logic [WIDTH-1:0]   ld_data_c;
    logic               ld_last_c;
    logic               accept_c;
    logic               hs_c;

    assign hs_c = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        load_c    = 1'b0;
        ld_data_c = rd;
        ld_last_c = 1'b0;
        accept_c  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = (first_addr > last_addr) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                load_c    = 1'b1;
                ld_data_c = rd;
`ifdef REGDUMP_CHECKSUM_EN
                ld_last_c = 1'b0;
`else
                ld_last_c = (cur_q == last_q);
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (hs_c) begin
                    accept_c = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d    = WIDTH'(sum_q + out_data);
`endif
                    // Equality test before increment keeps the top address from wrapping.
                    if (cur_q == last_q) begin
`ifdef REGDUMP_CHECKSUM_EN
                        load_c    = 1'b1;
                        ld_data_c = WIDTH'(sum_q + out_data);
                        ld_last_c = 1'b1;
                        state_d   = ST_CSUM;
`else
                        state_d   = ST_FINISH;
`endif
                    end else begin
                        cur_d   = REGBITS'(cur_q + 1'b1);
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (hs_c) begin
                    accept_c = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_FINISH);
        busy_d = (state_d != ST_IDLE);
    end

    regdump_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_c),
        .data_i   (ld_data_c),
        .last_i   (ld_last_c),
        .accept_i (accept_c),
        .valid_o  (out_valid),
        .data_o   (out_data),
        .last_o   (out_last)
    );

    assign ra   = cur_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized and directed bench for regfile_dump_reader against a queue-based
// model of the expected word stream (honours REGDUMP_CHECKSUM_EN).
module tb_regfile_dump_reader;

    localparam int unsigned W  = 16;
    localparam int unsigned RB = 4;
    localparam int unsigned NR = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [RB-1:0] first_addr;
    logic [RB-1:0] last_addr;
    logic [RB-1:0] ra;
    logic [W-1:0]  rd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [W-1:0]  regs [NR];
    logic          we;
    logic [RB-1:0] wa;
    logic [W-1:0]  wd;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Register file model: R0 reads as zero, writes land on the rising edge.
    always @(posedge clk) if (we) regs[wa] <= wd;
    assign rd = (ra == '0) ? '0 : regs[ra];

    regfile_dump_reader #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ra         (ra),
        .rd         (rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rf_val(input int a);
        return (a == 0) ? '0 : regs[a];
    endfunction

    // mode 0: always ready; 1: random ready; 2: stall 5 valid cycles on word stall_idx.
    task automatic run_dump(input int first, input int last, input int mode,
                            input int stall_idx, input bit wr_hit);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] sum;
        logic [W-1:0] prev_data;
        int  n, idx, cyc, first_valid, done_cyc, stall_cnt, exp_done;
        bit  prev_hold;
        sum = '0;
        for (int a = first; a <= last; a++) begin
            exp_q.push_back(rf_val(a));
            sum = W'(sum + rf_val(a));
        end
`ifdef REGDUMP_CHECKSUM_EN
        if (exp_q.size() > 0) exp_q.push_back(sum);
`endif
        n = exp_q.size();
        @(negedge clk);
        start      = 1'b1;
        first_addr = RB'(first);
        last_addr  = RB'(last);
        out_ready  = 1'b0;
        cyc = 0; idx = 0; first_valid = -1; done_cyc = -1; stall_cnt = 0;
        prev_hold = 1'b0; prev_data = '0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            we    = 1'b0;
            if (wr_hit && (cyc == 1 || cyc == 2)) begin
                we = 1'b1;
                wa = RB'(first);
                wd = W'(16'hA5A0 + cyc);
            end
            if (prev_hold) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            check_eq("busy_during", 32'(busy), 32'd1);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (idx == stall_idx && out_valid && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) begin
                if (idx < n) begin
                    check_eq("word_data", 32'(out_data), 32'(exp_q[idx]));
                    check_eq("word_last", 32'(out_last), 32'(idx == n - 1));
                end else begin
                    check_eq("word_count", 32'(idx + 1), 32'(n));
                end
                idx++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (done) done_cyc = cyc;
        end
        out_ready = 1'b0;
        we        = 1'b0;
        check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
        check_eq("accepted", 32'(idx), 32'(n));
        if (n > 0) check_eq("first_latency", 32'(first_valid), 32'd2);
        else       check_eq("no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        if (mode == 0) begin
`ifdef REGDUMP_CHECKSUM_EN
            exp_done = (n == 0) ? 1 : 2 * n;
`else
            exp_done = 2 * n + 1;
`endif
            check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
        end
        @(negedge clk);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("done_once", 32'(done), 32'd0);
    endtask

    task automatic reset_abort();
        int cyc;
        @(negedge clk);
        start = 1'b1; first_addr = 4'd0; last_addr = 4'd4; out_ready = 1'b1;
        cyc = 0;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc < 6) check_eq("abort_no_done", 32'(done), 32'd0);
        end
        check_eq("abort_third_valid", 32'(out_valid), 32'd1);
        check_eq("abort_third_data", 32'(out_data), 32'(rf_val(2)));
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("abort_idle_done", 32'(done), 32'd0);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int f, l;
        for (int i = 0; i < int'(NR); i++) regs[i] = W'($urandom);
        reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        out_ready = 1'b0; we = 1'b0; wa = '0; wd = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ra", 32'(ra), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        regs[1] = 16'h0011; regs[2] = 16'h0022; regs[3] = 16'h0033;
        run_dump(1, 3, 0, 0, 1'b0);
        run_dump(1, 3, 2, 1, 1'b0);
        regs[15] = 16'hBEEF;
        run_dump(15, 15, 0, 0, 1'b0);
        run_dump(5, 2, 0, 0, 1'b0);
        reset_abort();
        run_dump(0, 0, 0, 0, 1'b0);
        regs[1] = 16'hFFFF; regs[2] = 16'h0002;
        run_dump(1, 2, 0, 0, 1'b0);
        run_dump(1, 1, 2, 0, 1'b1);
        check_eq("write_landed", 32'(regs[1]), 32'h0000_A5A2);
        run_dump(0, 15, 1, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < int'(NR); i++) regs[i] = W'($urandom);
            f = int'($urandom_range(0, NR - 1));
            l = int'($urandom_range(0, NR - 1));
            run_dump(f, l, (t % 3 == 0) ? 0 : 1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
